// File: rtl/imul_iter_unit.sv
// imul_iter_unit: iterative shift-add 32x32 multiplier returning the low 32 product bits
// Ports: clk, reset (asynchronous, active-low)
//        req_val/req_rdy, req_a (multiplicand), req_b (multiplier) : request handshake
//        resp_val/resp_rdy, resp_result (low 32 bits of req_a*req_b) : response handshake
//        squash : kill the in-flight operation, busy : unit is not idle
module imul_iter_unit #(
    parameter bit p_early_exit = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_result,
    input  logic        squash,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t      state, state_nxt;
    logic [31:0] a_reg, b_reg, acc;
    logic [4:0]  cnt;
    logic        accept, last;
    assign accept = req_val && req_rdy;
    // the current iteration is the final one: 32nd pass, or no multiplier bits remain after it
    assign last = cnt == 5'd31 || (p_early_exit && b_reg[31:1] == 31'd0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    // squash takes priority over both the iteration exit and the response handshake
    always_comb begin
        state_nxt = state == IDLE ? (accept ? CALC : IDLE)
                  : state == CALC ? (squash ? IDLE : last ? DONE : CALC)
                  : state == DONE ? ((squash || resp_rdy) ? IDLE : DONE)
                  : IDLE;
    end
    always_comb begin
        req_rdy     = state == IDLE && !squash;
        resp_val    = state == DONE;
        resp_result = state == DONE ? acc : 32'd0;
        busy        = state != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= req_a;
            b_reg <= req_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            acc   <= b_reg[0] ? acc + a_reg : acc;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 5'd1;
        end
    end
endmodule
